// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - two-road light bus checker: phase decode, order/duration checks, sticky fault
// Optional completed-cycle counter port cycles_done is built when TRAFFIC_MON_COUNT_EN is defined.
module traffic_light_monitor #(
    parameter int GREEN1_CYC  = 5,
    parameter int YELLOW1_CYC = 2,
    parameter int GREEN2_CYC  = 5,
    parameter int YELLOW2_CYC = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       signal1_light,
    input  logic [2:0]       signal2_light,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] run_len,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_duration,
`ifdef TRAFFIC_MON_COUNT_EN
    output logic [7:0]       cycles_done,
`endif
    output logic             fault
);

    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_RED    = 3'b100;

    logic [2:0]       s1_q, s2_q;
    logic             smp_vld;
    logic [0:0]       state, state_d;
    logic             partial, partial_d;
    logic             overstay, overstay_d;
    logic [1:0]       phase_d, dec_phase, phase_inc;
    logic             valid_d;
    logic [CNT_W-1:0] run_d, exp_cur;
    logic             enc_d, conf_d, seq_d, dur_d, cyc_inc;
    logic             s1_ok, s2_ok, enc_bad, conflict, both_red, legal;

    function automatic logic [CNT_W-1:0] exp_len(input logic [1:0] p);
        case (p)
            2'd0:    return CNT_W'(GREEN1_CYC);
            2'd1:    return CNT_W'(YELLOW1_CYC);
            2'd2:    return CNT_W'(GREEN2_CYC);
            default: return CNT_W'(YELLOW2_CYC);
        endcase
    endfunction

    // smp_vld keeps the all-zero reset sample from being judged as an encoding error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 3'b000;
            s2_q    <= 3'b000;
            smp_vld <= 1'b0;
        end else begin
            s1_q    <= signal1_light;
            s2_q    <= signal2_light;
            smp_vld <= 1'b1;
        end
    end

    always_comb begin
        s1_ok     = (s1_q == L_GREEN) || (s1_q == L_YELLOW) || (s1_q == L_RED);
        s2_ok     = (s2_q == L_GREEN) || (s2_q == L_YELLOW) || (s2_q == L_RED);
        enc_bad   = !(s1_ok && s2_ok);
        conflict  = !enc_bad && (s1_q != L_RED) && (s2_q != L_RED);
        both_red  = !enc_bad && (s1_q == L_RED) && (s2_q == L_RED);
        legal     = !enc_bad && !conflict && !both_red;
        dec_phase = (s1_q == L_RED) ? {1'b1, s2_q == L_YELLOW} : {1'b0, s1_q == L_YELLOW};
        phase_inc = phase + 2'd1;
        exp_cur   = exp_len(phase);
    end

    always_comb begin
        state_d    = state;
        phase_d    = phase;
        valid_d    = phase_valid;
        run_d      = run_len;
        partial_d  = partial;
        overstay_d = overstay;
        enc_d      = 1'b0;
        conf_d     = 1'b0;
        seq_d      = 1'b0;
        dur_d      = 1'b0;
        cyc_inc    = 1'b0;
        if (smp_vld) begin
            if (!legal) begin
                enc_d   = enc_bad;
                conf_d  = conflict;
                seq_d   = both_red;
                state_d = ST_SYNC;
                valid_d = 1'b0;
                run_d   = '0;
            end else if (state == ST_SYNC) begin
                state_d    = ST_TRACK;
                valid_d    = 1'b1;
                phase_d    = dec_phase;
                run_d      = {{(CNT_W-1){1'b0}}, 1'b1};
                partial_d  = 1'b1;
                overstay_d = 1'b0;
            end else if (dec_phase == phase) begin
                if (run_len != '1)
                    run_d = run_len + 1'b1;
                // overstay is reported as soon as the run outlasts its budget, not at the change
                if (run_len == exp_cur && !overstay) begin
                    dur_d      = 1'b1;
                    overstay_d = 1'b1;
                end
            end else begin
                seq_d      = (dec_phase != phase_inc);
                dur_d      = !partial && !overstay && (run_len != exp_cur);
                cyc_inc    = (dec_phase == phase_inc) && (phase == 2'd3);
                phase_d    = dec_phase;
                run_d      = {{(CNT_W-1){1'b0}}, 1'b1};
                partial_d  = 1'b0;
                overstay_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_SYNC;
            phase        <= 2'd0;
            phase_valid  <= 1'b0;
            run_len      <= '0;
            partial      <= 1'b0;
            overstay     <= 1'b0;
            err_encoding <= 1'b0;
            err_conflict <= 1'b0;
            err_sequence <= 1'b0;
            err_duration <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_d;
            phase        <= phase_d;
            phase_valid  <= valid_d;
            run_len      <= run_d;
            partial      <= partial_d;
            overstay     <= overstay_d;
            err_encoding <= enc_d;
            err_conflict <= conf_d;
            err_sequence <= seq_d;
            err_duration <= dur_d;
            fault        <= enc_d | conf_d | seq_d | dur_d | (fault & ~clr_fault);
        end
    end

`ifdef TRAFFIC_MON_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cycles_done <= 8'd0;
        else if (cyc_inc)
            cycles_done <= cycles_done + 8'd1;
    end
`else
    logic unused_cyc_inc;
    assign unused_cyc_inc = cyc_inc;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] signal1_light = R;
    logic [2:0] signal2_light = R;
    logic       clr_fault = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic [3:0] run_len;
    logic       err_encoding, err_conflict, err_sequence, err_duration, fault;
`ifdef TRAFFIC_MON_COUNT_EN
    logic [7:0] cycles_done;
`endif

    traffic_light_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .signal1_light (signal1_light),
        .signal2_light (signal2_light),
        .clr_fault     (clr_fault),
        .phase         (phase),
        .phase_valid   (phase_valid),
        .run_len       (run_len),
        .err_encoding  (err_encoding),
        .err_conflict  (err_conflict),
        .err_sequence  (err_sequence),
        .err_duration  (err_duration),
`ifdef TRAFFIC_MON_COUNT_EN
        .cycles_done   (cycles_done),
`endif
        .fault         (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ph;
        logic       pv;
        logic [3:0] rl;
        logic       enc, conf, seq, dur, flt;
        logic [7:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // reference model state
    bit         m_track, m_partial, m_over, m_fault, prev_ok;
    int         m_phase, m_rl, m_cyc;
    logic [2:0] prev_s1, prev_s2;

    function automatic int exp_of(int p);
        case (p)
            0: return 5;
            1: return 2;
            2: return 5;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("phase", {6'd0, phase}, {6'd0, e.ph});
        chk("phase_valid", {7'd0, phase_valid}, {7'd0, e.pv});
        chk("run_len", {4'd0, run_len}, {4'd0, e.rl});
        chk("err_encoding", {7'd0, err_encoding}, {7'd0, e.enc});
        chk("err_conflict", {7'd0, err_conflict}, {7'd0, e.conf});
        chk("err_sequence", {7'd0, err_sequence}, {7'd0, e.seq});
        chk("err_duration", {7'd0, err_duration}, {7'd0, e.dur});
        chk("fault", {7'd0, fault}, {7'd0, e.flt});
`ifdef TRAFFIC_MON_COUNT_EN
        chk("cycles_done", cycles_done, e.cyc);
`endif
    endtask

    task automatic push_state(input bit enc, input bit conf, input bit seq, input bit dur);
        exp_t e;
        e.ph  = 2'(m_phase);
        e.pv  = m_track;
        e.rl  = 4'(m_rl);
        e.enc = enc;
        e.conf = conf;
        e.seq = seq;
        e.dur = dur;
        e.flt = m_fault;
        e.cyc = 8'(m_cyc);
        sb.push_back(e);
    endtask

    // judge the previously driven sample, as the DUT does on the edge after this drive
    task automatic model_step(input bit clr);
        bit enc = 0, conf = 0, seq = 0, dur = 0;
        int p = -1;
        if (prev_ok) begin
            case ({prev_s1, prev_s2})
                {G, R}: p = 0;
                {Y, R}: p = 1;
                {R, G}: p = 2;
                {R, Y}: p = 3;
                default: p = -1;
            endcase
            if (p < 0) begin
                if ($countones(prev_s1) != 1 || $countones(prev_s2) != 1) enc = 1;
                else if (prev_s1 != R && prev_s2 != R) conf = 1;
                else seq = 1;
                m_track = 0;
                m_rl = 0;
            end else if (!m_track) begin
                m_track = 1;
                m_phase = p;
                m_rl = 1;
                m_partial = 1;
                m_over = 0;
            end else if (p == m_phase) begin
                if (m_rl == exp_of(p) && !m_over) begin
                    dur = 1;
                    m_over = 1;
                end
                if (m_rl < 15) m_rl++;
            end else begin
                seq = (p != (m_phase + 1) % 4);
                dur = !m_partial && !m_over && (m_rl != exp_of(m_phase));
                if (!seq && m_phase == 3) m_cyc = (m_cyc + 1) % 256;
                m_phase = p;
                m_rl = 1;
                m_partial = 0;
                m_over = 0;
            end
        end
        m_fault = enc | conf | seq | dur | (m_fault & !clr);
        push_state(enc, conf, seq, dur);
    endtask

    task automatic check_pending();
        if (sb.size() > 0) compare(sb.pop_front());
    endtask

    task automatic drive(input logic [2:0] s1, input logic [2:0] s2, input bit clr);
        @(negedge clk);
        check_pending();
        signal1_light = s1;
        signal2_light = s2;
        clr_fault = clr;
        model_step(clr);
        prev_s1 = s1;
        prev_s2 = s2;
        prev_ok = 1;
    endtask

    task automatic drive_n(input logic [2:0] s1, input logic [2:0] s2, input int n);
        for (int i = 0; i < n; i++) drive(s1, s2, 1'b0);
    endtask

    task automatic model_reset();
        m_track = 0; m_partial = 0; m_over = 0; m_fault = 0;
        m_phase = 0; m_rl = 0; m_cyc = 0;
        prev_ok = 0;
        sb.delete();
    endtask

    // the bus present at release is captured on the first edge and judged on the second
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_fault = 1'b0;
        push_state(0, 0, 0, 0);
        prev_s1 = signal1_light;
        prev_s2 = signal2_light;
        prev_ok = 1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_phase", {6'd0, phase}, 8'd0);
        chk("rst_phase_valid", {7'd0, phase_valid}, 8'd0);
        chk("rst_run_len", {4'd0, run_len}, 8'd0);
        chk("rst_errors", {4'd0, err_encoding, err_conflict, err_sequence, err_duration}, 8'd0);
        chk("rst_fault", {7'd0, fault}, 8'd0);
`ifdef TRAFFIC_MON_COUNT_EN
        chk("rst_cycles_done", cycles_done, 8'd0);
`endif
    endtask

    initial begin
        model_reset();
        signal1_light = G;
        signal2_light = R;
        repeat (3) @(negedge clk);
        check_reset_outputs();

        // 1: legal cycle, first P0 run partial
        release_reset();
        drive_n(G, R, 3);
        drive_n(Y, R, 2);
        drive_n(R, G, 5);
        drive_n(R, Y, 2);
        drive_n(G, R, 5);
        // 2: conflicting greens
        drive(G, G, 1'b0);
        // 3: bad encoding, then both red
        drive(3'b011, R, 1'b0);
        drive(R, R, 1'b0);
        // 4: P0 jumping straight to P2
        drive_n(R, G, 3);
        drive_n(R, Y, 2);
        drive_n(G, R, 5);
        drive_n(R, G, 5);
        // 5: P0 overstay
        drive_n(R, Y, 2);
        drive_n(G, R, 8);
        drive_n(Y, R, 2);
        drive_n(R, G, 5);
        drive_n(R, Y, 2);
        drive_n(G, R, 5);
        // 6: clear racing a strobe, then clear alone
        drive(G, G, 1'b0);
        drive(R, G, 1'b1);
        drive(R, G, 1'b1);
        drive_n(R, G, 3);
        @(negedge clk);
        check_pending();
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        release_reset();
        drive_n(R, G, 2);
        drive_n(R, Y, 2);
        drive_n(G, R, 2);
        @(negedge clk);
        check_pending();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
